ex_mem_flags: RTL and testbench
===============================

Name: ex_mem_flags

Overview:
- Execute/memory boundary stage directly downstream of the 64-bit ALU.
- Captures the ALU result and control bits into the EX/MEM pipeline register.
- Holds the architectural NZVC flag register, written by flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves B.cond and CBZ; the registered outcome feeds PC select in the MEM cycle.

Parameters:
- WIDTH, 64, datapath width of result and store data.
- REGW, 5, register-specifier width.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold all stage state this cycle.
- flush  input  1  kill the instruction in EX; takes priority over stall.
- ex_valid  input  1  EX slot holds a real instruction.
- ex_result  input  WIDTH  ALU result.
- ex_negative, ex_zero, ex_overflow, ex_carry_out  input  1 each  ALU flags.
- ex_set_flags  input  1  instruction writes NZVC.
- ex_is_arith  input  1  add/sub op (V,C meaningful); 0 means logic op.
- ex_cond_br  input  1  B.cond instruction.
- ex_cbz  input  1  CBZ instruction (ALU passes B; uses ex_zero).
- ex_cond  input  4  condition code.
- ex_reg_wr, ex_mem_wr, ex_mem_rd  input  1 each  control bits.
- ex_rd  input  REGW  destination register.
- ex_store_data  input  WIDTH  store operand.
- mem_valid  output  1  registered valid.
- mem_result  output  WIDTH  registered result.
- mem_store_data  output  WIDTH  registered store data.
- mem_rd  output  REGW  registered destination.
- mem_reg_wr, mem_mem_wr, mem_mem_rd  output  1 each  registered control, gated by valid.
- mem_br_taken  output  1  registered branch decision.
- flag_n, flag_z, flag_v, flag_c  output  1 each  architectural flag register.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, flags 0, mem_valid 0, counters 0.
- Latency: one cycle EX→MEM for all captured fields.
- Priority per edge: reset > flush > stall > normal.
- Flush:
  - mem_valid, mem_reg_wr, mem_mem_wr, mem_mem_rd and mem_br_taken become 0.
  - Data fields are don't-care (hold).
  - Flags are not written.
- Stall without flush: every register, including flags, holds.
- Normal:
  - mem_* fields take their ex_* values; mem_valid takes ex_valid.
  - Control bits are ANDed with ex_valid.
- Flag write occurs when ex_valid && ex_set_flags && !stall && !flush:
  - N takes ex_negative; Z takes ex_zero.
  - V,C take ex_overflow/ex_carry_out if ex_is_arith, else 0.
- Branch decision:
  - mem_br_taken takes ex_valid && ((ex_cond_br && cond_true(ex_cond, current flag register)) || (ex_cbz && ex_zero)).
  - The flag register already reflects any flag-setter now in MEM, so no bypass is needed.
  - An instruction with both ex_set_flags and ex_cond_br evaluates against the old flags.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E/F AL (always true).
- Reset asserted mid-stall or mid-flush: reset wins and all state clears.

Optional Feature:
- Macro EXMEM_PERF_CNT_EN.
- With the macro defined, three 32-bit saturating counters are added, each with an output port of the same name, cleared on reset:
  - perf_insn: increments per non-flushed valid EX→MEM advance.
  - perf_br_taken: increments per mem_br_taken rising into the register.
  - perf_stall: increments each cycle stall && !flush.
- Each counter holds at 32'hFFFFFFFF.
- Without the macro: no counters and no ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - cond_t enum of the 16 condition codes.
  - flags_t packed struct {n,z,v,c}.
  - WIDTH/REGW defaults.
- Sub-module cond_eval: combinational, (cond_t, flags_t) → 1-bit true.
  - Reused later by conditional-select logic.

Test Plan:
- Reset held 2 cycles with ex_* all ones → all outputs 0, flags 0000.
- ADDS sequence:
  - ex_valid=1, set_flags=1, is_arith=1, result=64'h7000000000000002, N=0 Z=0 V=1 C=1 → next edge flags NZVC=0011, mem_result matches.
  - Then B.cond VS → mem_br_taken=1; B.cond VC → 0.
- Logic op with set_flags=1, is_arith=0, ex_overflow=1, ex_carry_out=1, result=64'h8000000000000000 → flags NZVC=1000.
- Stall held 3 cycles while ex_* changes → mem_* and flags unchanged; flush during stall → mem_valid=0, flags unchanged.
- CBZ: ex_cbz=1, ex_zero=1 → mem_br_taken=1; same with ex_valid=0 → 0, mem_reg_wr=0.
- Flags N=1,V=0 then B.cond GE → 0, LT → 1; with Z=1 and cond LE → 1; cond F → 1.

Source files
------------

// File: rtl/ex_mem_flags_pkg.sv
// rtl/ex_mem_flags_pkg.sv - shared types for the EX/MEM flag stage
package ex_mem_flags_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int REGW_DEF  = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

endpackage

// File: rtl/ex_mem_flags_cond_eval.sv
// rtl/ex_mem_flags_cond_eval.sv - combinational condition-code evaluator
module ex_mem_flags_cond_eval
  import ex_mem_flags_pkg::*;
(
  input  cond_t  cond_i,
  input  flags_t flags_i,
  output logic   true_o
);

  // Map the condition code onto the NZVC flags; E and F are both always-true
  always_comb begin
    true_o = 1'b1;
    case (cond_i)
      COND_EQ: true_o = flags_i.z;
      COND_NE: true_o = !flags_i.z;
      COND_HS: true_o = flags_i.c;
      COND_LO: true_o = !flags_i.c;
      COND_MI: true_o = flags_i.n;
      COND_PL: true_o = !flags_i.n;
      COND_VS: true_o = flags_i.v;
      COND_VC: true_o = !flags_i.v;
      COND_HI: true_o = flags_i.c && !flags_i.z;
      COND_LS: true_o = !flags_i.c || flags_i.z;
      COND_GE: true_o = (flags_i.n == flags_i.v);
      COND_LT: true_o = (flags_i.n != flags_i.v);
      COND_GT: true_o = !flags_i.z && (flags_i.n == flags_i.v);
      COND_LE: true_o = flags_i.z || (flags_i.n != flags_i.v);
      default: true_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_flags.sv
// rtl/ex_mem_flags.sv - EX/MEM pipeline register, NZVC flags and branch resolve; optional EXMEM_PERF_CNT_EN counters
module ex_mem_flags
  import ex_mem_flags_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REGW  = REGW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_negative,
  input  logic             ex_zero,
  input  logic             ex_overflow,
  input  logic             ex_carry_out,
  input  logic             ex_set_flags,
  input  logic             ex_is_arith,
  input  logic             ex_cond_br,
  input  logic             ex_cbz,
  input  logic [3:0]       ex_cond,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_wr,
  input  logic             ex_mem_rd,
  input  logic [REGW-1:0]  ex_rd,
  input  logic [WIDTH-1:0] ex_store_data,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [REGW-1:0]  mem_rd,
  output logic             mem_reg_wr,
  output logic             mem_mem_wr,
  output logic             mem_mem_rd,
  output logic             mem_br_taken,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]      perf_insn,
  output logic [31:0]      perf_br_taken,
  output logic [31:0]      perf_stall
`endif
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic             reg_wr_q, reg_wr_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             br_q, br_d;
  flags_t           flags_q, flags_d;

  logic             advance;
  logic             cond_true;
  logic             br_decision;

  assign advance = !stall && !flush;

  ex_mem_flags_cond_eval u_cond_eval (
    .cond_i  (cond_t'(ex_cond)),
    .flags_i (flags_q),
    .true_o  (cond_true)
  );

  // Branch outcome uses the current flag register, so a combined set+branch sees old flags
  assign br_decision = ex_valid && ((ex_cond_br && cond_true) || (ex_cbz && ex_zero));

  // Next-state for the pipeline register: flush kills control, stall holds, else capture
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    store_d  = store_q;
    rd_d     = rd_q;
    reg_wr_d = reg_wr_q;
    mem_wr_d = mem_wr_q;
    mem_rd_d = mem_rd_q;
    br_d     = br_q;
    if (flush) begin
      valid_d  = 1'b0;
      reg_wr_d = 1'b0;
      mem_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      br_d     = 1'b0;
    end else if (!stall) begin
      valid_d  = ex_valid;
      result_d = ex_result;
      store_d  = ex_store_data;
      rd_d     = ex_rd;
      reg_wr_d = ex_reg_wr && ex_valid;
      mem_wr_d = ex_mem_wr && ex_valid;
      mem_rd_d = ex_mem_rd && ex_valid;
      br_d     = br_decision;
    end
  end

  // Flag register write; logic ops clear V and C
  always_comb begin
    flags_d = flags_q;
    if (advance && ex_valid && ex_set_flags) begin
      flags_d.n = ex_negative;
      flags_d.z = ex_zero;
      flags_d.v = ex_is_arith ? ex_overflow  : 1'b0;
      flags_d.c = ex_is_arith ? ex_carry_out : 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      reg_wr_q <= 1'b0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      br_q     <= 1'b0;
      flags_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      reg_wr_q <= reg_wr_d;
      mem_wr_q <= mem_wr_d;
      mem_rd_q <= mem_rd_d;
      br_q     <= br_d;
      flags_q  <= flags_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_store_data = store_q;
  assign mem_rd         = rd_q;
  assign mem_reg_wr     = reg_wr_q;
  assign mem_mem_wr     = mem_wr_q;
  assign mem_mem_rd     = mem_rd_q;
  assign mem_br_taken   = br_q;
  assign flag_n         = flags_q.n;
  assign flag_z         = flags_q.z;
  assign flag_v         = flags_q.v;
  assign flag_c         = flags_q.c;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] perf_insn_q, perf_insn_d;
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating event counters: retired advances, captured taken branches, stall cycles
  always_comb begin
    perf_insn_d  = perf_insn_q;
    perf_br_d    = perf_br_q;
    perf_stall_d = perf_stall_q;
    if (advance && ex_valid && (perf_insn_q != 32'hFFFF_FFFF))
      perf_insn_d = perf_insn_q + 32'd1;
    if (advance && br_decision && (perf_br_q != 32'hFFFF_FFFF))
      perf_br_d = perf_br_q + 32'd1;
    if (stall && !flush && (perf_stall_q != 32'hFFFF_FFFF))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_insn_q  <= '0;
      perf_br_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_insn_q  <= perf_insn_d;
      perf_br_q    <= perf_br_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_insn     = perf_insn_q;
  assign perf_br_taken = perf_br_q;
  assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_flags.sv
// tb/tb_ex_mem_flags.sv - table-driven scoreboard bench for ex_mem_flags
module tb_ex_mem_flags;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_valid;
  logic [63:0] ex_result;
  logic        ex_negative, ex_zero, ex_overflow, ex_carry_out;
  logic        ex_set_flags, ex_is_arith, ex_cond_br, ex_cbz;
  logic [3:0]  ex_cond;
  logic        ex_reg_wr, ex_mem_wr, ex_mem_rd;
  logic [4:0]  ex_rd;
  logic [63:0] ex_store_data;
  logic        mem_valid;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_wr, mem_mem_wr, mem_mem_rd, mem_br_taken;
  logic        flag_n, flag_z, flag_v, flag_c;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] perf_insn, perf_br_taken, perf_stall;
`endif

  ex_mem_flags dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_result      (ex_result),
    .ex_negative    (ex_negative),
    .ex_zero        (ex_zero),
    .ex_overflow    (ex_overflow),
    .ex_carry_out   (ex_carry_out),
    .ex_set_flags   (ex_set_flags),
    .ex_is_arith    (ex_is_arith),
    .ex_cond_br     (ex_cond_br),
    .ex_cbz         (ex_cbz),
    .ex_cond        (ex_cond),
    .ex_reg_wr      (ex_reg_wr),
    .ex_mem_wr      (ex_mem_wr),
    .ex_mem_rd      (ex_mem_rd),
    .ex_rd          (ex_rd),
    .ex_store_data  (ex_store_data),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_reg_wr     (mem_reg_wr),
    .mem_mem_wr     (mem_mem_wr),
    .mem_mem_rd     (mem_mem_rd),
    .mem_br_taken   (mem_br_taken),
    .flag_n         (flag_n),
    .flag_z         (flag_z),
    .flag_v         (flag_v),
    .flag_c         (flag_c)
`ifdef EXMEM_PERF_CNT_EN
    ,
    .perf_insn      (perf_insn),
    .perf_br_taken  (perf_br_taken),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, fl, v, s, a;
    logic [3:0]  nzvc;
    logic        cbr, cbz;
    logic [3:0]  cond;
    logic        rw;
    logic [63:0] res;
    logic        e_v;
    logic [63:0] e_res;
    logic        e_rw, e_br;
    logic [3:0]  e_nzvc;
  } vec_t;

  typedef struct {
    string       tag;
    logic        v;
    logic [63:0] res, sd;
    logic [4:0]  rd;
    logic        rw, mw, mr, br;
    logic [3:0]  nzvc;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[$];

  logic [63:0] m_sd;
  logic [4:0]  m_rd;
  logic        m_mw, m_mr;

  function automatic vec_t mk(input logic st, input logic fl, input logic v, input logic s,
                              input logic a, input logic [3:0] nzvc, input logic cbr,
                              input logic cbz, input logic [3:0] cond, input logic rw,
                              input logic [63:0] res, input logic e_v, input logic [63:0] e_res,
                              input logic e_rw, input logic e_br, input logic [3:0] e_nzvc);
    vec_t r;
    r.st = st; r.fl = fl; r.v = v; r.s = s; r.a = a; r.nzvc = nzvc;
    r.cbr = cbr; r.cbz = cbz; r.cond = cond; r.rw = rw; r.res = res;
    r.e_v = e_v; r.e_res = e_res; r.e_rw = e_rw; r.e_br = e_br; r.e_nzvc = e_nzvc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    chk({e.tag, ".valid"}, 64'(mem_valid), 64'(e.v));
    chk({e.tag, ".result"}, mem_result, e.res);
    chk({e.tag, ".store"}, mem_store_data, e.sd);
    chk({e.tag, ".rd"}, 64'(mem_rd), 64'(e.rd));
    chk({e.tag, ".reg_wr"}, 64'(mem_reg_wr), 64'(e.rw));
    chk({e.tag, ".mem_wr"}, 64'(mem_mem_wr), 64'(e.mw));
    chk({e.tag, ".mem_rd"}, 64'(mem_mem_rd), 64'(e.mr));
    chk({e.tag, ".br"}, 64'(mem_br_taken), 64'(e.br));
    chk({e.tag, ".nzvc"}, 64'({flag_n, flag_z, flag_v, flag_c}), 64'(e.nzvc));
  endtask

  task automatic apply(input vec_t r, input int idx, input string tag);
    exp_t e, got;
    stall         = r.st;
    flush         = r.fl;
    ex_valid      = r.v;
    ex_set_flags  = r.s;
    ex_is_arith   = r.a;
    {ex_negative, ex_zero, ex_overflow, ex_carry_out} = r.nzvc;
    ex_cond_br    = r.cbr;
    ex_cbz        = r.cbz;
    ex_cond       = r.cond;
    ex_reg_wr     = r.rw;
    ex_result     = r.res;
    ex_store_data = ~r.res;
    ex_rd         = 5'(idx);
    ex_mem_wr     = idx[0];
    ex_mem_rd     = idx[1];
    if (r.fl) begin
      m_mw = 1'b0;
      m_mr = 1'b0;
    end else if (!r.st) begin
      m_sd = ~r.res;
      m_rd = 5'(idx);
      m_mw = idx[0] && r.v;
      m_mr = idx[1] && r.v;
    end
    e.tag = tag; e.v = r.e_v; e.res = r.e_res; e.sd = m_sd; e.rd = m_rd;
    e.rw = r.e_rw; e.mw = m_mw; e.mr = m_mr; e.br = r.e_br; e.nzvc = r.e_nzvc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, ".sb_pending"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      compare_outputs(got);
    end
  endtask

  task automatic check_all_zero(input string tag);
    exp_t z;
    z.tag = tag; z.v = 0; z.res = '0; z.sd = '0; z.rd = '0;
    z.rw = 0; z.mw = 0; z.mr = 0; z.br = 0; z.nzvc = 4'b0000;
    compare_outputs(z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    ex_valid = 1'b1; ex_result = '1; ex_negative = 1'b1; ex_zero = 1'b1;
    ex_overflow = 1'b1; ex_carry_out = 1'b1; ex_set_flags = 1'b1; ex_is_arith = 1'b1;
    ex_cond_br = 1'b1; ex_cbz = 1'b1; ex_cond = 4'hF; ex_reg_wr = 1'b1;
    ex_mem_wr = 1'b1; ex_mem_rd = 1'b1; ex_rd = '1; ex_store_data = '1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    m_sd = '0; m_rd = '0; m_mw = 1'b0; m_mr = 1'b0;

    //         st fl v  s  a  nzvc     cbr cbz cond rw res                    e_v e_res                 e_rw e_br e_nzvc
    tbl.push_back(mk(0,0,1,1,1,4'b0011,0,0,4'h0,1,64'h7000000000000002, 1,64'h7000000000000002,1,0,4'b0011));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h6,0,64'd1,  1,64'd1,  0,1,4'b0011));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h7,0,64'd2,  1,64'd2,  0,0,4'b0011));
    tbl.push_back(mk(0,0,1,1,0,4'b1011,0,0,4'h0,1,64'h8000000000000000, 1,64'h8000000000000000,1,0,4'b1000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hA,0,64'd4,  1,64'd4,  0,0,4'b1000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hB,0,64'd5,  1,64'd5,  0,1,4'b1000));
    tbl.push_back(mk(0,0,1,0,0,4'b0100,0,1,4'h0,1,64'd6,  1,64'd6,  1,1,4'b1000));
    tbl.push_back(mk(0,0,0,0,0,4'b0100,0,1,4'h0,1,64'd7,  0,64'd7,  0,0,4'b1000));
    tbl.push_back(mk(0,0,1,1,1,4'b0101,1,0,4'h0,1,64'd0,  1,64'd0,  1,0,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h0,0,64'd9,  1,64'd9,  0,1,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hD,0,64'd10, 1,64'd10, 0,1,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hF,0,64'd11, 1,64'd11, 0,1,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h8,0,64'd12, 1,64'd12, 0,0,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h9,0,64'd13, 1,64'd13, 0,1,4'b0101));
    tbl.push_back(mk(0,0,0,1,1,4'b1111,1,0,4'hF,1,64'd14, 0,64'd14, 0,0,4'b0101));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hC,0,64'd15, 1,64'd15, 0,0,4'b0101));
    tbl.push_back(mk(0,1,1,1,1,4'b1111,1,0,4'hF,1,64'hAA, 0,64'd15, 0,0,4'b0101));
    tbl.push_back(mk(1,1,1,1,1,4'b1111,1,0,4'hF,1,64'hBB, 0,64'd15, 0,0,4'b0101));
    tbl.push_back(mk(0,0,1,1,0,4'b0011,1,0,4'h2,1,64'd18, 1,64'd18, 1,1,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h1,0,64'd19, 1,64'd19, 0,1,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h4,0,64'd20, 1,64'd20, 0,0,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h5,0,64'd21, 1,64'd21, 0,1,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h7,0,64'd22, 1,64'd22, 0,1,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'h3,0,64'd23, 1,64'd23, 0,1,4'b0000));
    tbl.push_back(mk(0,0,1,0,0,4'b0000,1,0,4'hE,0,64'd24, 1,64'd24, 0,1,4'b0000));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], i, $sformatf("row%0d", i));

    // Capture, then three stall cycles with shifting inputs, then flush during stall
    apply(mk(0,0,1,1,1,4'b1001,0,0,4'h0,1,64'hDEAD, 1,64'hDEAD,1,0,4'b1001), 1, "stall_cap");
    apply(mk(1,0,1,1,1,4'b0110,1,0,4'hF,1,64'h1111, 1,64'hDEAD,1,0,4'b1001), 2, "stall1");
    apply(mk(1,0,0,1,0,4'b0100,0,1,4'h0,0,64'h2222, 1,64'hDEAD,1,0,4'b1001), 3, "stall2");
    apply(mk(1,0,1,1,1,4'b1111,1,1,4'hE,1,64'h3333, 1,64'hDEAD,1,0,4'b1001), 4, "stall3");
    apply(mk(1,1,1,1,1,4'b0000,1,0,4'hF,1,64'h4444, 0,64'hDEAD,0,0,4'b1001), 5, "stall_flush");
    apply(mk(0,0,1,0,0,4'b0000,1,0,4'hB,1,64'h5555, 1,64'h5555,1,1,4'b1001), 6, "post_stall_lt");

    // Reset asserted while stall is high clears everything
    reset = 1'b1; stall = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("reset_mid_stall");
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
